// File: rtl/count_checker.sv
// Sequence checker for an upstream 4-bit up counter: acquires lock after LOCK_CNT
// correct increments, flags breaks while locked. Macro COUNT_CHECKER_WRAP_EN enables wrap_count.
module count_checker #(
   parameter int unsigned LOCK_CNT = 3,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [3:0]       counter,
   output logic             locked,
   output logic             error,
   output logic [ERR_W-1:0] err_count,
   output logic [7:0]       wrap_count,
   output logic [3:0]       expected
);

   typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

   localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);

   state_t     state, state_nxt;
   logic [3:0] match_cnt, match_nxt;
   logic [3:0] expected_nxt;
   logic       locked_nxt;
   logic       error_nxt;
   logic       err_inc;
   logic       hit;

   assign hit = (counter == expected);

   always_comb begin
      state_nxt    = state;
      match_nxt    = match_cnt;
      expected_nxt = expected;
      locked_nxt   = locked;
      error_nxt    = 1'b0;
      err_inc      = 1'b0;
      if (en) begin
         expected_nxt = counter + 4'd1;
         unique case (state)
            IDLE: begin
               match_nxt = '0;
               state_nxt = ACQ;
            end
            ACQ: begin
               if (hit) begin
                  match_nxt = match_cnt + 4'd1;
                  if (match_cnt == LOCK_LAST) begin
                     state_nxt  = LOCK;
                     locked_nxt = 1'b1;
                  end
               end else begin
                  match_nxt = '0;
               end
            end
            LOCK: begin
               if (!hit) begin
                  error_nxt  = 1'b1;
                  err_inc    = 1'b1;
                  locked_nxt = 1'b0;
                  match_nxt  = '0;
                  state_nxt  = ACQ;
               end
            end
            default: begin
               state_nxt  = IDLE;
               locked_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         match_cnt <= '0;
         expected  <= '0;
         locked    <= 1'b0;
         error     <= 1'b0;
         err_count <= '0;
      end else begin
         state     <= state_nxt;
         match_cnt <= match_nxt;
         expected  <= expected_nxt;
         locked    <= locked_nxt;
         error     <= error_nxt;
         if (err_inc && (err_count != '1))
            err_count <= err_count + ERR_W'(1);
      end
   end

`ifdef COUNT_CHECKER_WRAP_EN
   // Only a correct 15->0 step seen while already locked counts as a wrap.
   always_ff @(posedge clk) begin
      if (reset)
         wrap_count <= '0;
      else if (en && (state == LOCK) && hit && (counter == 4'd0))
         wrap_count <= wrap_count + 8'd1;
   end
`else
   assign wrap_count = '0;
`endif

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench for count_checker: directed samples push expected outputs,
// a monitor pops and compares one entry per clock.
module tb_count_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic [3:0] counter = '0;
   logic       locked;
   logic       error;
   logic [7:0] err_count;
   logic [7:0] wrap_count;
   logic [3:0] expected;

`ifdef COUNT_CHECKER_WRAP_EN
   localparam bit WRAP_ON = 1'b1;
`else
   localparam bit WRAP_ON = 1'b0;
`endif

   typedef struct packed {
      logic       locked;
      logic       error;
      logic [7:0] err;
      logic [7:0] wrap;
      logic [3:0] exp;
   } resp_t;

   resp_t sb[$];
   int    total = 0;
   int    bad   = 0;

   count_checker #(.LOCK_CNT(3), .ERR_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .counter    (counter),
      .locked     (locked),
      .error      (error),
      .err_count  (err_count),
      .wrap_count (wrap_count),
      .expected   (expected)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [7:0] act, logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endfunction

   initial begin : monitor
      resp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("locked",     {7'd0, locked}, {7'd0, e.locked});
            chk("error",      {7'd0, error},  {7'd0, e.error});
            chk("err_count",  err_count,      e.err);
            chk("wrap_count", wrap_count,     e.wrap);
            chk("expected",   {4'd0, expected}, {4'd0, e.exp});
         end
      end
   end

   task automatic step(input logic r, input logic e, input logic [3:0] c,
                       input logic xl, input logic xe, input logic [7:0] xerr,
                       input logic [7:0] xwrap_hits, input logic [3:0] xexp);
      resp_t x;
      @(negedge clk);
      reset   = r;
      en      = e;
      counter = c;
      @(posedge clk);
      #1;
      x.locked = xl;
      x.error  = xe;
      x.err    = xerr;
      x.wrap   = WRAP_ON ? xwrap_hits : 8'd0;
      x.exp    = xexp;
      sb.push_back(x);
   endtask

   initial begin : stim
      logic [3:0] cur;
      logic [3:0] badv;
      logic [7:0] errx;

      // reset state
      step(1, 0, 0,  0, 0, 0, 0, 0);
      // acquire on 0,1,2,3
      step(0, 1, 0,  0, 0, 0, 0, 1);
      step(0, 1, 1,  0, 0, 0, 0, 2);
      step(0, 1, 2,  0, 0, 0, 0, 3);
      step(0, 1, 3,  1, 0, 0, 0, 4);
      step(0, 1, 4,  1, 0, 0, 0, 5);
      step(0, 1, 5,  1, 0, 0, 0, 6);
      step(0, 1, 6,  1, 0, 0, 0, 7);
      // break while locked, then relock
      step(0, 1, 9,  0, 1, 1, 0, 10);
      step(0, 1, 10, 0, 0, 1, 0, 11);
      step(0, 1, 11, 0, 0, 1, 0, 12);
      step(0, 1, 12, 1, 0, 1, 0, 13);
      // en low with counter moving: everything held
      step(0, 0, 3,  1, 0, 1, 0, 13);
      step(0, 0, 9,  1, 0, 1, 0, 13);
      step(0, 0, 0,  1, 0, 1, 0, 13);
      step(0, 0, 13, 1, 0, 1, 0, 13);
      step(0, 0, 15, 1, 0, 1, 0, 13);
      step(0, 1, 13, 1, 0, 1, 0, 14);
      // wrap 14,15,0,1
      step(0, 1, 14, 1, 0, 1, 0, 15);
      step(0, 1, 15, 1, 0, 1, 0, 0);
      step(0, 1, 0,  1, 0, 1, 1, 1);
      step(0, 1, 1,  1, 0, 1, 1, 2);
      // break, partial reacquire, mismatch in ACQ clears progress silently
      step(0, 1, 5,  0, 1, 2, 1, 6);
      step(0, 1, 6,  0, 0, 2, 1, 7);
      step(0, 1, 7,  0, 0, 2, 1, 8);
      step(0, 1, 3,  0, 0, 2, 1, 4);
      step(0, 1, 4,  0, 0, 2, 1, 5);
      step(0, 1, 5,  0, 0, 2, 1, 6);
      step(0, 1, 6,  1, 0, 2, 1, 7);
      // reset while locked with err_count=2, en high
      step(1, 1, 7,  0, 0, 0, 0, 0);
      // first sample after release behaves as IDLE
      step(0, 1, 5,  0, 0, 0, 0, 6);
      step(0, 1, 6,  0, 0, 0, 0, 7);
      step(0, 1, 7,  0, 0, 0, 0, 8);
      step(0, 1, 8,  1, 0, 0, 0, 9);
      // 2^8+3 breaks, each after relocking: err_count saturates at 255
      cur = 4'd9;
      for (int i = 1; i <= 259; i++) begin
         badv = cur + 4'd3;
         errx = (i > 255) ? 8'd255 : 8'(i);
         step(0, 1, badv, 0, 1, errx, 0, badv + 4'd1);
         step(0, 1, badv + 4'd1, 0, 0, errx, 0, badv + 4'd2);
         step(0, 1, badv + 4'd2, 0, 0, errx, 0, badv + 4'd3);
         step(0, 1, badv + 4'd3, 1, 0, errx, 0, badv + 4'd4);
         cur = badv + 4'd4;
      end

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 3: consecutive correct increments required to declare lock (legal 1..15).
REQ-002 SHALL have parameter ERR_W, default 8: width of the saturating error counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  sample strobe; the counter value is sampled only in cycles with en=1.
REQ-006 SHALL have port counter  input  4  observed value from an upstream 4-bit up counter.
REQ-007 SHALL have port locked  output  1  high while the checker tracks a correct sequence.
REQ-008 SHALL have port error  output  1  one-cycle pulse per detected sequence break while locked.
REQ-009 SHALL have port err_count  output  ERR_W  saturating count of error pulses.
REQ-010 SHALL have port wrap_count  output  8  count of correct 15->0 wraps while locked, modulo 256.
REQ-011 SHALL have port expected  output  4  next value the checker predicts.

Function
REQ-012 SHALL implement FSM states IDLE, ACQ, LOCK; all outputs registered.
REQ-013 IDLE: on en, SHALL set expected=counter+1 (mod 16), clear match count, go to ACQ.
REQ-014 ACQ, en and counter==expected: SHALL increment match count and set expected=counter+1; on reaching LOCK_CNT, SHALL go to LOCK and assert locked the following cycle.
REQ-015 ACQ, en and mismatch: SHALL clear match count, set expected=counter+1, stay in ACQ, leave error low.
REQ-016 LOCK, en and match: SHALL set expected=counter+1; if counter==0, SHALL increment wrap_count.
REQ-017 LOCK, en and mismatch: SHALL pulse error for exactly the next cycle, increment err_count, deassert locked, clear match count, set expected=counter+1, go to ACQ.
REQ-018 err_count SHALL saturate at 2^ERR_W-1; wrap_count SHALL roll over 255->0.
REQ-019 en=0 SHALL hold state, expected, counts, and locked; error SHALL be 0.
REQ-020 Latency: every response to a sample taken at edge N SHALL be visible after edge N.
REQ-021 Arithmetic on expected SHALL be modulo 16 (15+1=0).

Reset
REQ-022 reset=1 at a rising edge SHALL force IDLE, locked=0, error=0, err_count=0, wrap_count=0, expected=0, match count=0.
REQ-023 reset SHALL take priority over en, including mid-acquisition or while locked.
REQ-024 The first sample after reset release SHALL be treated as in IDLE; no error SHALL result from it.

Configuration
REQ-025 Macro COUNT_CHECKER_WRAP_EN SHALL gate the wrap counter.
REQ-026 Defined: wrap_count SHALL behave per REQ-016/REQ-018.
REQ-027 Undefined: no wrap register SHALL exist, wrap_count SHALL be constant 0, and all other behaviour SHALL be unchanged.

Verification
REQ-028 Apply reset 1 cycle, then en=1 with counter 0,1,2,3 -> locked=1 after the 4th sample, expected=4, error never high.
REQ-029 While locked at expected=7, drive counter=9 -> error high for one cycle, err_count=1, locked=0, expected=10; then 10,11,12 -> locked=1 again.
REQ-030 Locked with the sequence 14,15,0,1 -> wrap_count=1 with the macro defined, 0 without it; no error.
REQ-031 Force 2^ERR_W+3 mismatches, each after relocking -> err_count stays at 2^ERR_W-1.
REQ-032 Locked, with en=0 for 5 cycles and counter changing -> no state change; then resume with the expected value -> still locked.
REQ-033 Assert reset while locked with err_count=2 -> next cycle all outputs 0 and state IDLE.
